// File: rtl/demux2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : demux2_pkg
//  Purpose  : Shared types and constants for the two-way registered demux.
//             Holds the per-slot buffer state enumeration and the default
//             data-path / counter widths used by demux2_reg and demux_slot.
//  Revision : 1.0  initial release
// ============================================================================
package demux2_pkg;

  // One-entry slot buffer: EMPTY means no undelivered word, FULL means the
  // slot's valid output is asserted.
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  localparam int DEFAULT_WIDTH     = 32;
  localparam int DEFAULT_CNT_WIDTH = 8;

endpackage : demux2_pkg
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
//  Module   : demux_slot
//  Purpose  : One-entry output buffer with a completed-transfer counter.
//             A load refills the slot; a valid/ready handshake drains it.
//             Load and drain on the same edge keep the slot FULL with the
//             new word, giving one word per cycle.
//  Ports    : clk, reset (async, active high)
//             load   - write din into the slot this edge
//             din    - data word to store
//             ready  - downstream consumer accepts dout this cycle
//             valid  - slot holds an undelivered word
//             dout   - stored word (kept when the slot drains)
//             count  - completed output transfers, wrapping
//  Revision : 1.0  initial release
// ============================================================================
module demux_slot
  import demux2_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [WIDTH-1:0]     din,
  input  logic                 ready,
  output logic                 valid,
  output logic [WIDTH-1:0]     dout,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  slot_state_t          state;
  slot_state_t          next_state;
  logic                 out_xfer;
  logic [WIDTH-1:0]     data;
  logic [CNT_WIDTH-1:0] cnt;

  assign valid    = (state == FULL);
  assign out_xfer = valid & ready;
  assign dout     = data;
  assign count    = cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      EMPTY:   if (load) next_state = FULL;
      FULL:    if (!load && ready) next_state = EMPTY;
      default: next_state = EMPTY;
    endcase
  end

  // Data only moves on a load, so a drained slot keeps showing its last word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= '0;
    end else if (load) begin
      data <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (out_xfer) begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule : demux_slot
`default_nettype wire

// File: rtl/demux2_reg.sv
`default_nettype none
// ============================================================================
//  Module   : demux2_reg
//  Purpose  : Registered 1-to-2 demultiplexer with valid/ready handshakes.
//             sel steers E into slot 0 or slot 1; each slot is a one-entry
//             buffer so a stalled destination blocks only its own traffic.
//  Ports    : clk, reset (async, active high)
//             sel, E, in_valid, in_ready        - input stream
//             S0, S0_valid, S0_ready            - output 0 stream
//             S1, S1_valid, S1_ready            - output 1 stream
//             cnt0, cnt1                        - per-output transfer counts
//  Revision : 1.0  initial release
// ============================================================================
module demux2_reg
  import demux2_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sel,
  input  logic [WIDTH-1:0]     E,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     S0,
  output logic                 S0_valid,
  input  logic                 S0_ready,
  output logic [WIDTH-1:0]     S1,
  output logic                 S1_valid,
  input  logic                 S1_ready,
  output logic [CNT_WIDTH-1:0] cnt0,
  output logic [CNT_WIDTH-1:0] cnt1
);

  logic slot0_open;
  logic slot1_open;
  logic accept;
  logic load0;
  logic load1;

  // A slot can take a word if it is empty or is being drained this cycle.
  // in_ready looks only at the addressed slot and never at in_valid.
  assign slot0_open = ~S0_valid | S0_ready;
  assign slot1_open = ~S1_valid | S1_ready;
  assign in_ready   = sel ? slot1_open : slot0_open;

  assign accept = in_valid & in_ready;
  assign load0  = accept & ~sel;
  assign load1  = accept &  sel;

  demux_slot #(
    .WIDTH    (WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_slot0 (
    .clk  (clk),
    .reset(reset),
    .load (load0),
    .din  (E),
    .ready(S0_ready),
    .valid(S0_valid),
    .dout (S0),
    .count(cnt0)
  );

  demux_slot #(
    .WIDTH    (WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_slot1 (
    .clk  (clk),
    .reset(reset),
    .load (load1),
    .din  (E),
    .ready(S1_ready),
    .valid(S1_valid),
    .dout (S1),
    .count(cnt1)
  );

endmodule : demux2_reg
`default_nettype wire

// File: tb/tb_demux2_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux2_reg
//  Purpose  : Self-checking bench for demux2_reg: table of directed vectors
//             plus hand-written reset, streaming, wrap and idle sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_demux2_reg;

  logic        clk;
  logic        reset;
  logic        sel;
  logic [31:0] E;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] S0;
  logic        S0_valid;
  logic        S0_ready;
  logic [31:0] S1;
  logic        S1_valid;
  logic        S1_ready;
  logic [7:0]  cnt0;
  logic [7:0]  cnt1;

  int tests;
  int fails;

  demux2_reg dut (
    .clk     (clk),
    .reset   (reset),
    .sel     (sel),
    .E       (E),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .S0      (S0),
    .S0_valid(S0_valid),
    .S0_ready(S0_ready),
    .S1      (S1),
    .S1_valid(S1_valid),
    .S1_ready(S1_ready),
    .cnt0    (cnt0),
    .cnt1    (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [31:0] e;
    logic        vld;
    logic        r0;
    logic        r1;
    logic        exp_rdy;
    logic [31:0] exp_s0;
    logic        exp_v0;
    logic [31:0] exp_s1;
    logic        exp_v1;
    logic [7:0]  exp_c0;
    logic [7:0]  exp_c1;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [31:0] s0, input logic v0,
                          input logic [31:0] s1, input logic v1,
                          input logic [7:0] c0, input logic [7:0] c1);
    chk({tag, ".S0"},       S0,              s0);
    chk({tag, ".S0_valid"}, {31'd0, S0_valid}, {31'd0, v0});
    chk({tag, ".S1"},       S1,              s1);
    chk({tag, ".S1_valid"}, {31'd0, S1_valid}, {31'd0, v1});
    chk({tag, ".cnt0"},     {24'd0, cnt0},   {24'd0, c0});
    chk({tag, ".cnt1"},     {24'd0, cnt1},   {24'd0, c1});
  endtask

  // Drive inputs, check the combinational in_ready, then clock once and
  // leave the caller 1 time unit after the rising edge.
  task automatic step(input string tag, input logic s, input logic [31:0] e,
                      input logic v, input logic r0, input logic r1,
                      input logic exp_rdy);
    sel = s; E = e; in_valid = v; S0_ready = r0; S1_ready = r1;
    #1;
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, exp_rdy});
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    sel = 1'b0; E = '0; in_valid = 1'b0; S0_ready = 1'b0; S1_ready = 1'b0;

    //            sel  E             vld r0 r1 rdy  S0            v0  S1            v1  c0 c1
    vecs[0] = '{1'b0, 32'h00000011, 1, 1, 1, 1, 32'h00000011, 1, 32'h00000000, 0, 8'd0, 8'd0};
    vecs[1] = '{1'b1, 32'h00000022, 1, 1, 1, 1, 32'h00000011, 0, 32'h00000022, 1, 8'd1, 8'd0};
    vecs[2] = '{1'b0, 32'h00000000, 0, 1, 1, 1, 32'h00000011, 0, 32'h00000022, 0, 8'd1, 8'd1};
    vecs[3] = '{1'b0, 32'h00000033, 1, 0, 1, 1, 32'h00000033, 1, 32'h00000022, 0, 8'd1, 8'd1};
    vecs[4] = '{1'b0, 32'hAAAA5555, 1, 0, 1, 0, 32'h00000033, 1, 32'h00000022, 0, 8'd1, 8'd1};
    vecs[5] = '{1'b1, 32'h12345678, 1, 0, 0, 1, 32'h00000033, 1, 32'h12345678, 1, 8'd1, 8'd1};
    vecs[6] = '{1'b1, 32'h00000099, 1, 0, 0, 0, 32'h00000033, 1, 32'h12345678, 1, 8'd1, 8'd1};
    vecs[7] = '{1'b1, 32'h00000077, 1, 0, 1, 1, 32'h00000033, 1, 32'h00000077, 1, 8'd1, 8'd2};
    vecs[8] = '{1'b0, 32'h00000044, 1, 1, 0, 1, 32'h00000044, 1, 32'h00000077, 1, 8'd2, 8'd2};
    vecs[9] = '{1'b1, 32'hFFFFFFFF, 0, 1, 1, 1, 32'h00000044, 0, 32'h00000077, 0, 8'd3, 8'd3};

    // Reset state while reset is held.
    #2;
    chk_outs("rst_hold", 32'd0, 1'b0, 32'd0, 1'b0, 8'd0, 8'd0);
    chk("rst_hold.in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed vector table: steering, backpressure, isolation, refill.
    for (int i = 0; i < 10; i++) begin
      step($sformatf("vec%0d", i), vecs[i].sel, vecs[i].e, vecs[i].vld,
           vecs[i].r0, vecs[i].r1, vecs[i].exp_rdy);
      chk_outs($sformatf("vec%0d", i), vecs[i].exp_s0, vecs[i].exp_v0,
               vecs[i].exp_s1, vecs[i].exp_v1, vecs[i].exp_c0, vecs[i].exp_c1);
    end

    // Streaming: 10 back-to-back words into slot 1, sink always ready.
    for (int i = 0; i < 10; i++) begin
      step($sformatf("strm%0d", i), 1'b1, 32'h0000_1000 + i, 1'b1, 1'b1, 1'b1, 1'b1);
      chk($sformatf("strm%0d.S1", i), S1, 32'h0000_1000 + i);
      chk($sformatf("strm%0d.S1_valid", i), {31'd0, S1_valid}, 32'd1);
    end
    step("strm_drain", 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk_outs("strm_end", 32'h44, 1'b0, 32'h0000_1009, 1'b0, 8'd3, 8'd13);

    // Mid-cycle asynchronous reset with slot 0 holding DEADBEEF.
    step("rst_load", 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_load.S0", S0, 32'hDEADBEEF);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk_outs("rst_async", 32'd0, 1'b0, 32'd0, 1'b0, 8'd0, 8'd0);
    chk("rst_async.in_ready", {31'd0, in_ready}, 32'd1);
    #1;
    reset = 1'b0;
    // First edge after release must accept.
    step("post_rst", 1'b1, 32'h00000055, 1'b1, 1'b1, 1'b0, 1'b1);
    chk_outs("post_rst", 32'd0, 1'b0, 32'h55, 1'b1, 8'd0, 8'd0);
    step("post_rst_drain", 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk_outs("post_rst_drain", 32'd0, 1'b0, 32'h55, 1'b0, 8'd0, 8'd1);

    // Counter wrap: 256 output-0 transfers.
    for (int i = 0; i < 256; i++) begin
      step($sformatf("wrap%0d", i), 1'b0, i, 1'b1, 1'b1, 1'b1, 1'b1);
      chk($sformatf("wrap%0d.cnt0", i), {24'd0, cnt0}, i);
    end
    chk("wrap_pre.cnt0", {24'd0, cnt0}, 32'd255);
    step("wrap_drain", 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk_outs("wrap_end", 32'd255, 1'b0, 32'h55, 1'b0, 8'd0, 8'd1);

    // Idle inputs: sel/E toggle with in_valid low, nothing may change.
    for (int i = 0; i < 20; i++) begin
      step($sformatf("idle%0d", i), i[0], $urandom, 1'b0, $urandom_range(0, 1),
           $urandom_range(0, 1), 1'b1);
      chk_outs($sformatf("idle%0d", i), 32'd255, 1'b0, 32'h55, 1'b0, 8'd0, 8'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_demux2_reg
`default_nettype wire

// File: doc/demux2_reg.md
DEMUX2_REG -- requirements
Module: demux2_reg

Interface
REQ-001 Parameter WIDTH, default 32: width of the data path.
REQ-002 Parameter CNT_WIDTH, default 8: width of each transfer counter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sel  input  1  destination select: 0 -> output 0, 1 -> output 1; sampled with E.
REQ-006 E  input  WIDTH  input data word.
REQ-007 in_valid  input  1  E and sel are valid this cycle.
REQ-008 in_ready  output  1  block accepts E this cycle.
REQ-009 S0  output  WIDTH  data word held for output 0.
REQ-010 S0_valid  output  1  S0 holds an undelivered word.
REQ-011 S0_ready  input  1  output 0 consumer accepts S0 this cycle.
REQ-012 S1, S1_valid, S1_ready: same as REQ-009 to REQ-011, for output 1.
REQ-013 cnt0  output  CNT_WIDTH  number of completed output-0 transfers, modulo 2^CNT_WIDTH.
REQ-014 cnt1  output  CNT_WIDTH  number of completed output-1 transfers, modulo 2^CNT_WIDTH.

Function
REQ-015 An input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; E goes to slot k, with k = sel.
REQ-016 An output transfer on slot k SHALL occur on a rising edge where Sk_valid=1 and Sk_ready=1.
REQ-017 Each slot SHALL be a one-entry buffer with two states, EMPTY (Sk_valid=0) and FULL (Sk_valid=1).
REQ-018 EMPTY -> FULL on an input transfer to that slot.
REQ-019 FULL -> EMPTY on an output transfer with no simultaneous input transfer to that slot.
REQ-020 FULL stays FULL with Sk replaced by the new E when an input and an output transfer hit the same slot on the same edge; throughput SHALL be one word per cycle per slot.
REQ-021 in_ready SHALL be combinational: 1 when the slot selected by the current sel is EMPTY, or FULL with its Sk_ready=1; otherwise 0.
REQ-022 in_ready SHALL NOT depend on in_valid.
REQ-023 Latency SHALL be exactly one cycle: Sk_valid rises on the edge that accepts E, and Sk equals that E.
REQ-024 While Sk_valid=1 and Sk_ready=0, Sk SHALL remain stable.
REQ-025 A full slot k SHALL block only words addressed to k.
REQ-026 A transfer to the other slot SHALL proceed regardless of slot k's state.
REQ-027 An input transfer to slot k SHALL NOT alter the other slot's data, valid or counter.
REQ-028 When a slot goes EMPTY, Sk SHALL retain its last value.
REQ-029 cntk SHALL increment by 1 on each output transfer of slot k and wrap from 2^CNT_WIDTH-1 to 0.
REQ-030 When in_valid=0, sel and E SHALL have no effect on state.

Reset
REQ-031 reset=1 SHALL, asynchronously and without waiting for clk, force both slots EMPTY and set S0, S1, cnt0 and cnt1 to 0.
REQ-032 While reset=1, S0_valid and S1_valid SHALL be 0.
REQ-033 Because both slots are EMPTY during and after reset, in_ready SHALL be 1.
REQ-034 A word held in a slot when reset asserts SHALL be discarded and not counted.
REQ-035 The first transfer after reset SHALL be accepted on the first rising edge following reset deassertion.

Structure
REQ-036 Shared package demux2_pkg SHALL hold the slot-state enumeration (EMPTY, FULL) and the constants DEFAULT_WIDTH=32 and DEFAULT_CNT_WIDTH=8.
REQ-037 Sub-module demux_slot SHALL implement one buffer slot:
  - contents: state, data register, transfer counter;
  - ports: clk, reset, load, data in, ready in; valid out, data out, count out;
  - instantiated twice, with the top level producing in_ready and the per-slot load strobes.

Verification
REQ-038 Reset: assert reset mid-cycle with slot 0 FULL (S0=32'hDEADBEEF) -> S0_valid=0, S0=0 and cnt0=0 immediately; in_ready=1.
REQ-039 Steering:
  - stimulus: sel=0, E=32'h00000011, then sel=1, E=32'h00000022, both sinks ready;
  - response: S0=11h with S0_valid one cycle after the first accept, S1=22h one cycle after the second;
  - response: cnt0=1, cnt1=1.
REQ-040 Backpressure isolation:
  - stimulus: S0_ready=0 with slot 0 FULL, then sel=0, E=32'hAAAA5555;
  - response: in_ready=0 and S0 unchanged;
  - stimulus: switch to sel=1, E=32'h12345678;
  - response: in_ready=1 and S1 loads 12345678h next cycle.
REQ-041 Streaming: 10 back-to-back words to slot 1 with S1_ready=1 -> one accept per cycle, in order, and cnt1=10.
REQ-042 Counter wrap: 256 output-0 transfers -> cnt0 goes 255 to 0 on the 256th transfer, and cnt1 is unchanged.
REQ-043 Idle inputs: in_valid=0 while E and sel toggle for 20 cycles -> no state, data or counter change.
